// File: rtl/seqmul_pkg.sv
// seqmul_pkg: shared types and helpers for the sequential shift-add multiplier.
//   state_t   : FSM state encoding (IDLE, RUN, DONE), 2 bits.
//   cnt_width : iteration-counter width for an N-bit operand, ceil(log2(N+1)).
package seqmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter width so that values 0..N are representable.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/four_bit_adder.sv
// four_bit_adder: 4-bit ripple adder slice with carry in/out.
// Ports:
//   a_i, b_i [3:0] : addends
//   cin_i          : carry in
//   sum_o  [3:0]   : a_i + b_i + cin_i, low 4 bits
//   cout_o         : carry out
module four_bit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] total_s;

  // Widen to 5 bits so the carry-out falls out of the addition.
  always_comb begin
    total_s = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
  end

  assign sum_o  = total_s[3:0];
  assign cout_o = total_s[4];

endmodule

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential N x N unsigned shift-add multiplier.
// One multiplier bit is consumed per clock; the add stage is a chain of
// N/4 four_bit_adder slices with ripple carry.
// Ports:
//   i_clk, i_rst_n    : clock, synchronous active-low reset
//   i_valid, o_ready  : operand handshake (i_a multiplicand, i_b multiplier)
//   o_valid, i_ready  : product handshake
//   o_product [2N-1:0]: exact unsigned product, held stable while o_valid
// Build option: define SEQMUL_ZERO_SKIP_EN to bypass iteration when either
// operand is zero (result 0 presented one cycle after acceptance).
module seq_shift_add_mult
  import seqmul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*N-1:0] o_product
);

  localparam int CNT_W  = cnt_width(N);
  localparam int STAGES = N / 4;

  state_t             state_q, state_d;
  logic [N-1:0]       m_q, m_d;
  logic [2*N-1:0]     p_q, p_d;   // {acc, Q}
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N-1:0]       addend_s;
  logic [N-1:0]       sum_s;
  logic [STAGES:0]    carry_s;

  // Partial-product selection: add M only when the current multiplier bit is set.
  always_comb begin
    if (p_q[0]) begin
      addend_s = m_q;
    end else begin
      addend_s = {N{1'b0}};
    end
  end

  assign carry_s[0] = 1'b0;

  for (genvar g = 0; g < STAGES; g++) begin : g_add
    four_bit_adder u_add (
      .a_i   (p_q[N + 4*g +: 4]),
      .b_i   (addend_s[4*g +: 4]),
      .cin_i (carry_s[g]),
      .sum_o (sum_s[4*g +: 4]),
      .cout_o(carry_s[g+1])
    );
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          m_d   = i_a;
          p_d   = {{N{1'b0}}, i_b};
          cnt_d = {CNT_W{1'b0}};
`ifdef SEQMUL_ZERO_SKIP_EN
          if ((i_a == {N{1'b0}}) || (i_b == {N{1'b0}})) begin
            p_d     = {(2*N){1'b0}};
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // {C, sum, Q} >> 1: the final carry becomes the new MSB, so no bits
        // of the exact product are lost.
        p_d   = {carry_s[STAGES], sum_s, p_q[N-1:1]};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      m_q     <= {N{1'b0}};
      p_q     <= {(2*N){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_product = p_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

`ifdef SEQMUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  logic        clk;
  logic        rst_n;

  logic        valid4, ready4;
  logic [3:0]  a4, b4;
  logic        o_ready4, o_valid4;
  logic [7:0]  o_product4;

  logic        valid8, ready8;
  logic [7:0]  a8, b8;
  logic        o_ready8, o_valid8;
  logic [15:0] o_product8;

  int checks;
  int failures;
  int hs4;

  seq_shift_add_mult #(.N(4)) dut4 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid4),
    .o_ready  (o_ready4),
    .i_a      (a4),
    .i_b      (b4),
    .o_valid  (o_valid4),
    .i_ready  (ready4),
    .o_product(o_product4)
  );

  seq_shift_add_mult #(.N(8)) dut8 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid8),
    .o_ready  (o_ready8),
    .i_a      (a8),
    .i_b      (b8),
    .o_valid  (o_valid8),
    .i_ready  (ready8),
    .o_product(o_product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed product handshakes on the N=4 instance.
  always @(posedge clk) begin
    if (rst_n && o_valid4 && ready4) hs4 <= hs4 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where o_valid is first seen.
  task automatic txn4(input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] prod, output int lat);
    check("n4_accept_ready", {31'd0, o_ready4}, 32'd1);
    a4 = a; b4 = b; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    lat = 1;
    while (o_valid4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    prod = o_product4;
  endtask

  task automatic txn8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] prod, output int lat);
    check("n8_accept_ready", {31'd0, o_ready8}, 32'd1);
    a8 = a; b8 = b; valid8 = 1'b1;
    @(negedge clk);
    valid8 = 1'b0;
    lat = 1;
    while (o_valid8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    prod = o_product8;
  endtask

  initial begin
    logic [7:0]  p4;
    logic [15:0] p8;
    int          lat;
    int          hs_start;
    int          stall;

    checks = 0; failures = 0; hs4 = 0;
    rst_n = 1'b0;
    valid4 = 1'b0; ready4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    valid8 = 1'b0; ready8 = 1'b0; a8 = 8'd0; b8 = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready4", {31'd0, o_ready4}, 32'd1);
    check("rst_valid4", {31'd0, o_valid4}, 32'd0);
    check("rst_ready8", {31'd0, o_ready8}, 32'd1);
    check("rst_valid8", {31'd0, o_valid8}, 32'd0);

    // 15 x 15 with i_ready held high: one-cycle o_valid, latency 5
    ready4 = 1'b1;
    txn4(4'd15, 4'd15, p4, lat);
    check("p15x15", {24'd0, p4}, 32'd225);
    check("lat15x15", lat, 32'd5);
    @(negedge clk);
    check("valid_one_cycle", {31'd0, o_valid4}, 32'd0);
    check("ready_after_done", {31'd0, o_ready4}, 32'd1);

    // 5 x 3 with back-pressure for 10 cycles and ignored i_valid pulses
    ready4 = 1'b0;
    txn4(4'd5, 4'd3, p4, lat);
    check("p5x3", {24'd0, p4}, 32'd15);
    check("lat5x3", lat, 32'd5);
    for (int i = 0; i < 10; i++) begin
      valid4 = i[0];
      a4 = 4'd9; b4 = 4'd9;
      @(negedge clk);
      check("hold_product", {24'd0, o_product4}, 32'd15);
      check("hold_valid", {31'd0, o_valid4}, 32'd1);
      check("hold_ready", {31'd0, o_ready4}, 32'd0);
    end
    valid4 = 1'b0;
    ready4 = 1'b1;
    check("ready_low_at_iready", {31'd0, o_ready4}, 32'd0);
    @(negedge clk);
    check("release_ready", {31'd0, o_ready4}, 32'd1);
    check("release_valid", {31'd0, o_valid4}, 32'd0);
    @(negedge clk);
    check("no_queued_txn", {31'd0, o_valid4}, 32'd0);

    // Zero operand
    txn4(4'd0, 4'd9, p4, lat);
    check("p0x9", {24'd0, p4}, 32'd0);
    check("lat0x9", lat, ZLAT);
    @(negedge clk);

    // Reset mid-RUN, then a clean 7 x 6
    a4 = 4'd12; b4 = 4'd11; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun_rst_ready", {31'd0, o_ready4}, 32'd1);
    check("midrun_rst_valid", {31'd0, o_valid4}, 32'd0);
    txn4(4'd7, 4'd6, p4, lat);
    check("p7x6", {24'd0, p4}, 32'd42);
    check("lat7x6", lat, 32'd5);
    @(negedge clk);

    // N=8 corner products
    ready8 = 1'b1;
    txn8(8'd255, 8'd255, p8, lat);
    check("p255x255", {16'd0, p8}, 32'd65025);
    check("lat255x255", lat, 32'd9);
    @(negedge clk);
    txn8(8'd128, 8'd2, p8, lat);
    check("p128x2", {16'd0, p8}, 32'd256);
    check("lat128x2", lat, 32'd9);
    @(negedge clk);

    // Exhaustive N=4 with random stalls
    hs_start = hs4;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        ready4 = 1'b0;
        txn4(ai[3:0], bi[3:0], p4, lat);
        check("exh_valid_seen", {31'd0, o_valid4}, 32'd1);
        check("exh_product", {24'd0, p4}, ai * bi);
        stall = $urandom_range(0, 3);
        repeat (stall) @(negedge clk);
        check("exh_product_held", {24'd0, o_product4}, ai * bi);
        ready4 = 1'b1;
        @(negedge clk);
      end
    end
    ready4 = 1'b0;
    @(negedge clk);
    check("exh_handshakes", hs4 - hs_start, 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
# seq_shift_add_mult

Sequential N×N unsigned shift-add multiplier for the multipliers path. Accepts one operand pair per transaction over a valid/ready handshake. Iterates one multiplier bit per clock through a chain of `four_bit_adder` instances, which form its combinational add stage. Presents a 2N-bit product with its own valid/ready handshake.

## Interface
- `N`, default 4: operand width. Must be a multiple of 4, minimum 4. Sets the adder chain length to N/4.
- `i_clk` input 1: clock. All state updates on the rising edge.
- `i_rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `i_clk`.
- `i_valid` input 1: operand pair valid.
- `o_ready` output 1: block can accept an operand pair.
- `i_a` input N: multiplicand, unsigned.
- `i_b` input N: multiplier, unsigned.
- `o_valid` output 1: product valid.
- `i_ready` input 1: downstream accepts the product.
- `o_product` output 2N: `i_a * i_b`, unsigned, exact with no truncation.

## Operation
- State registers:
  - M (N bits): multiplicand.
  - P (2N bits): upper half acc, lower half Q.
  - Carry bit C.
  - Iteration counter cnt: ceil(log2(N+1)) bits.
  - FSM state.
- FSM states:
  - IDLE:
    - `o_ready`=1.
    - On `i_valid`: M←`i_a`, P←{N'b0, `i_b`}, cnt←0, go to RUN.
  - RUN, one iteration per cycle:
    - sum,C ← acc + (Q[0] ? M : 0) through the adder chain, carry-in 0.
    - P ← {C, sum, Q} >> 1.
    - cnt←cnt+1.
    - After the N-th iteration (cnt==N−1 at the edge), go to DONE.
  - DONE:
    - `o_valid`=1 and `o_product`=P, held stable.
    - On `i_ready`, go to IDLE.
- Arithmetic: the adder chain is N bits wide with ripple carry between chain stages. The carry-out of the last stage becomes the shifted-in MSB, so the result is exact for all 2^(2N) operand pairs.
- `o_ready` is 0 in RUN and DONE. `i_valid` in those states is ignored and not queued.
- DONE with `i_ready`=1 goes to IDLE. A new transaction cannot be accepted in the same cycle because `o_ready` was low.
- `o_product` outside DONE: undefined for checking purposes. Implementation drives P.
- Reset, at any state including mid-RUN:
  - FSM←IDLE, M, P, C, cnt←0.
  - `o_valid`=0, `o_ready`=1 in the following cycle.
  - Any in-flight operation is discarded.

## Timing
- Accept edge (`i_valid` & `o_ready`) is edge 0.
- Iterations occur on edges 1..N. `o_valid` is high in the cycle after edge N.
- Latency: N+1 cycles from accept edge to the first `o_valid` cycle.
- Minimum transaction period, with `i_ready` held high: N+2 cycles.
- Back-pressure: `o_valid` and `o_product` stay constant until the `i_ready` edge.
- Critical path: full N-bit ripple through the adder chain plus the P mux, within one cycle.

## Configuration
- `SEQMUL_ZERO_SKIP_EN` defined:
  - At acceptance, if `i_a`==0 or `i_b`==0, go IDLE→DONE directly with P←0.
  - `o_valid` is high the cycle after the accept edge, giving a latency of 1.
- Undefined:
  - Zero operands take the full N-iteration path.
  - Result (0) is identical; only latency differs.

## Structure
- Shared package `seqmul_pkg`:
  - FSM state enum (IDLE, RUN, DONE) with 2-bit encoding.
  - Localparam for counter width as a function of N.
- Sub-module: N/4 instances of `four_bit_adder` chained Cout→Cin, forming the add stage. No other sub-modules.

## Test plan
- N=4, `i_a`=15, `i_b`=15, `i_ready`=1 → `o_product`=225, `o_valid` high exactly 5 cycles after the accept edge, for one cycle.
- N=4, `i_a`=5, `i_b`=3, `i_ready` held 0 for 10 cycles after `o_valid` → `o_product`=15 stable throughout. `o_ready`=0 until the cycle after `i_ready` rises. `i_valid` pulses during the hold are ignored.
- N=4, `i_a`=0, `i_b`=9 → product 0.
  - With `SEQMUL_ZERO_SKIP_EN`: latency 1.
  - Without: latency 5.
- N=4, accept `i_a`=12, `i_b`=11, assert `i_rst_n`=0 at iteration 2 → next cycle IDLE, `o_ready`=1, `o_valid`=0. A following 7×6 transaction yields 42.
- N=8, `i_a`=255, `i_b`=255 → 65025. Then `i_a`=128, `i_b`=2 → 256. Latency 9 each.
- N=4, exhaustive 256 operand pairs back-to-back with random `i_ready` stalls → every product equals `i_a*i_b`, in order, with none lost or duplicated.
